// File: rtl/pc_unit.sv
// pc_unit: program counter and instruction fetch for the unpipelined Beta-style core.
// Sequences IDLE -> FETCH -> EXEC. FETCH waits on an IMEM_REQ/IMEM_ACK
// handshake. EXEC presents one instruction to the control unit for a single
// cycle. The PC advances on the edge that leaves EXEC. PC[31] is the
// supervisor bit. All arithmetic stays inside PC[30:0].
module pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h80000000,
  parameter logic [31:0] ILLOP_VEC = 32'h80000004,
  parameter logic [31:0] XADR_VEC  = 32'h80000008,
  parameter int unsigned TIMEOUT   = 16            // legal range 2..255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  PCSEL,
  input  logic [31:0] JT,
  input  logic        IRQ_IN,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] instruction,
  output logic        INSTR_VALID,
  output logic        IRQ,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FETCH_ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  // PCSEL encodings driven by the control unit.
  localparam logic [2:0] SEL_PLUS4 = 3'd0;
  localparam logic [2:0] SEL_BRNCH = 3'd1;
  localparam logic [2:0] SEL_JMP   = 3'd2;
  localparam logic [2:0] SEL_ILLOP = 3'd3;
  localparam logic [2:0] SEL_XADR  = 3'd4;

  // Last counter value before a fetch is declared timed out.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_irq_pending;
  logic        r_fetch_err;
  logic [7:0]  r_count;

  logic        w_in_fetch;
  logic        w_in_exec;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_sum;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_next_pc;
  logic        w_unused_bits;

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_in_exec  = (r_state == S_EXEC);

  // Increment wraps inside bits [30:0]; the supervisor bit passes through.
  assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};

  // Branch displacement is a sign-extended word offset. Only the low 31 bits
  // of the sum are kept, so the branch can never change the supervisor bit.
  assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_sum    = w_pc_plus4 + w_br_offset;
  assign w_br_target = {r_pc[31], w_br_sum[30:0]};

  // A jump may drop supervisor mode but never raise it. It always lands word-aligned.
  assign w_jmp_target = {r_pc[31] & JT[31], JT[30:2], 2'b00};

  // These bits are deliberately discarded by the target computations above.
  assign w_unused_bits = &{1'b0, JT[1:0], w_br_sum[31]};

  // Next-PC multiplexer. Undefined selects fall back to the illegal-op vector.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
    w_next_pc = ILLOP_VEC;
    case (PCSEL)
      SEL_PLUS4: w_next_pc = w_pc_plus4;
      SEL_BRNCH: w_next_pc = w_br_target;
      SEL_JMP:   w_next_pc = w_jmp_target;
      SEL_ILLOP: w_next_pc = ILLOP_VEC;
      SEL_XADR:  w_next_pc = XADR_VEC;
      default:   w_next_pc = ILLOP_VEC;
    endcase
  end

  // Sequencer next state. FETCH holds until the memory acknowledges.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: if (IMEM_ACK) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sequencer state register. Reset is asynchronous, so IMEM_REQ drops immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Fetch capture and timeout watchdog. An ACK on the timeout edge takes priority.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_instr     <= '0;
      r_count     <= '0;
      r_fetch_err <= 1'b0;
    end else if (w_in_fetch) begin
      if (IMEM_ACK) begin
        r_instr <= IMEM_DATA;
        r_count <= '0;
      end else if (r_count == CNT_LAST) begin
        r_fetch_err <= 1'b1;
        r_count     <= '0;
      end else begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  // The program counter advances only on the edge that leaves EXEC.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          r_pc <= RESET_VEC;
    else if (w_in_exec) r_pc <= w_next_pc;
  end

  // Latches interrupt requests. Taking the interrupt clears the latch and wins over a new request on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                  r_irq_pending <= 1'b0;
    else if (w_in_exec && (PCSEL == SEL_XADR))  r_irq_pending <= 1'b0;
    else if (IRQ_IN)                            r_irq_pending <= 1'b1;
  end

  assign IMEM_REQ    = w_in_fetch;
  assign IMEM_ADDR   = {1'b0, r_pc[30:2], 2'b00};
  assign instruction = r_instr;
  assign INSTR_VALID = w_in_exec;
  assign IRQ         = r_irq_pending & ~r_pc[31] & w_in_exec;
  assign PC          = r_pc;
  assign PC_PLUS4    = w_pc_plus4;
  assign FETCH_ERR   = r_fetch_err;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit. Each program step pushes its
// expected EXEC view when its fetch starts, then pops and compares it in EXEC.
module tb_pc_unit;

  logic        CLK;
  logic        RESET;
  logic [2:0]  PCSEL;
  logic [31:0] JT;
  logic        IRQ_IN;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] instruction;
  logic        INSTR_VALID;
  logic        IRQ;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        FETCH_ERR;

  int checks = 0;
  int errors = 0;

  // One program step: the expected PC of this instruction, the number of FETCH
  // cycles without ACK, the instruction word, the PCSEL/JT to apply in EXEC,
  // and whether IRQ_IN pulses for one cycle during the fetch.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dly;
    logic [31:0] data;
    logic [2:0]  sel;
    logic [31:0] jt;
    logic        pulse;
  } step_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        irq;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  logic m_pend = 1'b0;
  logic m_err  = 1'b0;

  localparam int NSTEP = 25;
  step_t prog [NSTEP] = '{
    '{32'h80000000, 5'd1,  32'h80000000, 3'd0, 32'h00000000, 1'b0},
    '{32'h80000004, 5'd0,  32'h00000000, 3'd2, 32'h00000100, 1'b0},
    '{32'h00000100, 5'd2,  32'h0000FFFE, 3'd1, 32'h00000000, 1'b0},
    '{32'h000000FC, 5'd0,  32'h00000000, 3'd2, 32'h00000100, 1'b0},
    '{32'h00000100, 5'd1,  32'h00000003, 3'd1, 32'h00000000, 1'b0},
    '{32'h00000110, 5'd0,  32'h00000000, 3'd4, 32'h00000000, 1'b0},
    '{32'h80000008, 5'd0,  32'h00000000, 3'd0, 32'h00000000, 1'b0},
    '{32'h8000000C, 5'd0,  32'h00000000, 3'd0, 32'h00000000, 1'b0},
    '{32'h80000010, 5'd1,  32'h00000000, 3'd2, 32'h00000207, 1'b0},
    '{32'h00000204, 5'd0,  32'h00000000, 3'd2, 32'h80000040, 1'b0},
    '{32'h00000040, 5'd0,  32'h00000000, 3'd6, 32'h00000000, 1'b0},
    '{32'h80000004, 5'd0,  32'h00000000, 3'd2, 32'h80000020, 1'b0},
    '{32'h80000020, 5'd2,  32'h00000000, 3'd2, 32'h00000300, 1'b1},
    '{32'h00000300, 5'd0,  32'h00000000, 3'd4, 32'h00000000, 1'b0},
    '{32'h80000008, 5'd0,  32'h00000000, 3'd2, 32'h00000400, 1'b0},
    '{32'h00000400, 5'd15, 32'h12345678, 3'd0, 32'h00000000, 1'b0},
    '{32'h00000404, 5'd16, 32'h9ABCDEF0, 3'd0, 32'h00000000, 1'b0},
    '{32'h00000408, 5'd0,  32'h00000000, 3'd2, 32'h7FFFFFFF, 1'b0},
    '{32'h7FFFFFFC, 5'd0,  32'h00000000, 3'd0, 32'h00000000, 1'b0},
    '{32'h00000000, 5'd0,  32'h00000000, 3'd5, 32'h00000000, 1'b0},
    '{32'h80000004, 5'd0,  32'h00000000, 3'd2, 32'hFFFFFFFC, 1'b0},
    '{32'hFFFFFFFC, 5'd0,  32'h00000000, 3'd0, 32'h00000000, 1'b0},
    '{32'h80000000, 5'd0,  32'h00000000, 3'd7, 32'h00000000, 1'b0},
    '{32'h80000004, 5'd0,  32'h00000000, 3'd3, 32'h00000000, 1'b0},
    '{32'h80000004, 5'd0,  32'h0000ABCD, 3'd0, 32'h00000000, 1'b0}
  };

  pc_unit dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PCSEL      (PCSEL),
    .JT         (JT),
    .IRQ_IN     (IRQ_IN),
    .IMEM_ACK   (IMEM_ACK),
    .IMEM_DATA  (IMEM_DATA),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .instruction(instruction),
    .INSTR_VALID(INSTR_VALID),
    .IRQ        (IRQ),
    .PC         (PC),
    .PC_PLUS4   (PC_PLUS4),
    .FETCH_ERR  (FETCH_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bounded wait for the DUT to raise IMEM_REQ, sampled on falling edges.
  task automatic wait_req();
    int n = 0;
    while (IMEM_REQ !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("req_wait", {31'd0, IMEM_REQ}, 32'd1);
  endtask

  task automatic run_step(input step_t s);
    exp_t        e;
    logic [31:0] addr;
    wait_req();
    if (s.pulse) m_pend = 1'b1;
    if (s.dly >= 5'd16) m_err = 1'b1;
    e.pc    = s.pc;
    e.pc4   = {s.pc[31], s.pc[30:0] + 31'd4};
    e.instr = s.data;
    e.irq   = m_pend & ~s.pc[31];
    e.err   = m_err;
    sb_q.push_back(e);
    addr = {1'b0, s.pc[30:2], 2'b00};
    check("fetch_addr", IMEM_ADDR, addr);
    check("fetch_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("fetch_irq", {31'd0, IRQ}, 32'd0);
    if (s.pulse) IRQ_IN = 1'b1;
    for (int i = 0; i < int'(s.dly); i++) begin
      IMEM_DATA = $urandom;
      @(posedge CLK);
      @(negedge CLK);
      IRQ_IN = 1'b0;
      check("wait_addr", IMEM_ADDR, addr);
      check("wait_req", {31'd0, IMEM_REQ}, 32'd1);
    end
    IMEM_ACK  = 1'b1;
    IMEM_DATA = s.data;
    @(posedge CLK);
    @(negedge CLK);
    IMEM_ACK  = 1'b0;
    IRQ_IN    = 1'b0;
    IMEM_DATA = 32'h0BAD0BAD;
    check("exec_valid", {31'd0, INSTR_VALID}, 32'd1);
    check("exec_req", {31'd0, IMEM_REQ}, 32'd0);
    check("sb_size", sb_q.size(), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("exec_pc", PC, e.pc);
      check("exec_pc4", PC_PLUS4, e.pc4);
      check("exec_instr", instruction, e.instr);
      check("exec_irq", {31'd0, IRQ}, {31'd0, e.irq});
      check("exec_err", {31'd0, FETCH_ERR}, {31'd0, e.err});
    end
    PCSEL = s.sel;
    JT    = s.jt;
    if (s.sel == 3'd4) m_pend = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RESET     = 1'b1;
    PCSEL     = 3'd0;
    JT        = 32'd0;
    IRQ_IN    = 1'b0;
    IMEM_ACK  = 1'b0;
    IMEM_DATA = 32'd0;
    repeat (2) @(negedge CLK);
    check("rst_pc", PC, 32'h80000000);
    check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
    check("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_err", {31'd0, FETCH_ERR}, 32'd0);

    RESET = 1'b0;
    check("idle_req", {31'd0, IMEM_REQ}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);

    for (int k = 0; k < NSTEP; k++) run_step(prog[k]);
    check("err_sticky", {31'd0, FETCH_ERR}, 32'd1);

    // Reset in the middle of a fetch, with an ACK that lands in IDLE.
    check("pre_rst_req", {31'd0, IMEM_REQ}, 32'd1);
    RESET = 1'b1;
    #1;
    check("midrst_req", {31'd0, IMEM_REQ}, 32'd0);
    check("midrst_pc", PC, 32'h80000000);
    check("midrst_err", {31'd0, FETCH_ERR}, 32'd0);
    @(negedge CLK);
    RESET     = 1'b0;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 32'hDEADBEEF;
    check("idle2_req", {31'd0, IMEM_REQ}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    check("late_ack_instr", instruction, 32'd0);
    check("late_ack_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("refetch_req", {31'd0, IMEM_REQ}, 32'd1);
    m_pend = 1'b0;
    m_err  = 1'b0;
    run_step('{32'h80000000, 5'd0, 32'h13572468, 3'd0, 32'h00000000, 1'b0});
    run_step('{32'h80000004, 5'd1, 32'h0000FFFF, 3'd0, 32'h00000000, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Sequential program-counter and instruction-fetch block for the unpipelined Beta-style core.
- Consumes the control unit's PCSEL selection and the JT/branch operands, and keeps the PC, including the supervisor bit PC[31].
- Fetches instructions from instruction memory over a REQ/ACK handshake and drives the instruction word, the masked IRQ and PC+4 back to the control unit and the WDSEL=00 write-back path.

Parameters:
RESET_VEC, 32'h80000000, PC loaded on reset.
ILLOP_VEC, 32'h80000004, PC target for PCSEL=3 and for undefined PCSEL 5-7.
XADR_VEC, 32'h80000008, PC target for PCSEL=4 (interrupt).
TIMEOUT, 16, FETCH cycles without IMEM_ACK before FETCH_ERR is set (range 2..255).

Ports:
CLK  input  1  clock; all state changes on its rising edge.
RESET  input  1  asynchronous, active-high reset.
PCSEL  input  3  next-PC select from the CU; sampled only in EXEC.
JT  input  32  jump target (register-file RA data).
IRQ_IN  input  1  raw external interrupt request, level.
IMEM_ACK  input  1  instruction memory returns IMEM_DATA this cycle.
IMEM_DATA  input  32  instruction word, valid with IMEM_ACK.
IMEM_REQ  output  1  fetch request.
IMEM_ADDR  output  32  fetch address.
instruction  output  32  registered instruction word to the CU.
INSTR_VALID  output  1  high in EXEC; CU outputs are meaningful only then.
IRQ  output  1  interrupt request to the CU.
PC  output  32  current PC.
PC_PLUS4  output  32  {PC[31], PC[30:0]+4}.
FETCH_ERR  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset, asynchronous, immediate: PC=RESET_VEC, state=IDLE, IMEM_REQ=0, instruction=0, INSTR_VALID=0, IRQ=0, irq_pending=0, FETCH_ERR=0, timeout counter=0.
- A reset asserted mid-FETCH drops IMEM_REQ at once. A late IMEM_ACK is ignored.

State machine (IDLE, FETCH, EXEC):
- IDLE: outputs quiet; moves to FETCH on the first edge after RESET deasserts.
- FETCH:
  - IMEM_REQ=1 and IMEM_ADDR={1'b0, PC[30:2], 2'b00}; both are stable for the whole wait.
  - On an edge with IMEM_ACK=1: instruction<=IMEM_DATA, counter<=0, go to EXEC.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ACK: FETCH_ERR<=1, counter<=0, stay in FETCH and keep requesting the same address.
  - ACK on the same edge as the timeout: the ACK wins and FETCH_ERR is not set.
- EXEC:
  - Lasts exactly 1 cycle with IMEM_REQ=0 and INSTR_VALID=1.
  - On the next edge: PC<=next_pc(PCSEL), go to FETCH.
  - IMEM_ACK seen in IDLE or EXEC is ignored.

Fetch timing:
- Fetch-to-execute latency = ACK latency + 1 cycle.
- With zero-wait memory (ACK in the first FETCH cycle) an instruction completes every 2 cycles.

next_pc:
- 0: PC_PLUS4.
- 1: PC_PLUS4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}. Addition is on bits [30:0] modulo 2^31; bit 31 is kept from PC.
- 2: {PC[31] & JT[31], JT[30:2], 2'b00}. A jump can leave supervisor mode but never enter it; JT[1:0] are forced to 0.
- 3: ILLOP_VEC.
- 4: XADR_VEC.
- 5, 6, 7: ILLOP_VEC.

Arithmetic:
- PC_PLUS4 wraps inside bits [30:0]; 0x7FFFFFFC -> 0x00000000 and 0xFFFFFFFC -> 0x80000000.

Interrupts:
- irq_pending is set on any edge with IRQ_IN=1.
- irq_pending is cleared on the EXEC edge where PCSEL=4. If set and clear fall on the same edge, clear wins; irq_pending re-sets on the next edge if IRQ_IN is still high.
- IRQ = irq_pending & ~PC[31] & INSTR_VALID. Interrupts are masked in supervisor mode and never asserted outside EXEC.
- FETCH_ERR clears only on RESET.

Test Plan:
1. Reset and first fetch:
   - Stimulus: RESET pulse, ACK one cycle after REQ, IMEM_DATA=32'h80000000, PCSEL=0.
   - Response: PC=0x80000000 during reset; first IMEM_ADDR=0x00000000; INSTR_VALID for 1 cycle; next PC=0x80000004, PC_PLUS4=0x80000008.
2. Branch:
   - Stimulus: PC=0x00000100, instruction[15:0]=16'hFFFE, PCSEL=1.
   - Response: next PC=0x000000FC. Repeat with 16'h0003: next PC=0x00000110.
3. Jump:
   - Stimulus: PC=0x80000010, JT=0x00000207, PCSEL=2.
   - Response: PC=0x00000204. Then from user PC 0x00000204 with JT=0x80000040: PC=0x00000040 (no supervisor entry).
4. Interrupt:
   - Stimulus: IRQ_IN 1-cycle pulse while PC=0x80000020.
   - Response: IRQ=0 in EXEC. After a jump to user mode, IRQ=1 in EXEC; with PCSEL=4, PC=0x80000008, then IRQ=0 on the next EXEC.
5. Timeout and handshake:
   - Stimulus: withhold ACK for 16 FETCH cycles, then ACK.
   - Response: FETCH_ERR=1 after cycle 16; IMEM_ADDR is unchanged throughout; the instruction is accepted on ACK; FETCH_ERR stays 1 until RESET.
6. Reset mid-fetch and undefined select:
   - Stimulus: assert RESET while IMEM_REQ=1, with ACK arriving in the IDLE cycle.
   - Response: IMEM_REQ=0 immediately; instruction stays 0; PC=0x80000000.
   - Separately, PCSEL=3'b110 in EXEC: next PC=0x80000004.
